clct_lut_buffer: RTL

Post-LUT stage of the CLCT pattern finder. Each BX it takes the two candidates after pattern-LUT lookup: quarter-strip offset, bend and quality, plus the key half-strip delayed from the pattern finder. It applies a quality threshold, orders the pair by quality and enforces a programmable dead time. Accepted events go into an 8-deep first-word-fall-through FIFO, which a valid/ready handshake drains toward the sequencer/readout.

---
 rtl/clct_lut_buffer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/clct_lut_buffer.sv
// Post-LUT stage of the CLCT pattern finder: quality threshold, pair sort,
// programmable dead time and an 8-deep first-word-fall-through output FIFO.
module clct_lut_buffer #(
  parameter int MXQSB   = 4,
  parameter int MXBNDB  = 5,
  parameter int MXQLTB  = 9,
  parameter int MXKEYB  = 8,
  parameter int MXFADRB = 3
) (
  input  logic                                            clock,
  input  logic                                            reset_n,
  input  logic                                            lut_vld,
  input  logic [MXKEYB-1:0]                               key0,
  input  logic [MXKEYB-1:0]                               key1,
  input  logic [MXQSB-1:0]                                qs0,
  input  logic [MXQSB-1:0]                                qs1,
  input  logic [MXBNDB-1:0]                               bend0,
  input  logic [MXBNDB-1:0]                               bend1,
  input  logic [MXQLTB-1:0]                               quality0,
  input  logic [MXQLTB-1:0]                               quality1,
  input  logic [MXQLTB-1:0]                               qlt_thresh,
  input  logic [3:0]                                      dead_time,
  output logic                                            out_vld,
  input  logic                                            out_rdy,
  output logic [2*(1+MXKEYB+MXQSB+MXBNDB+MXQLTB)-1:0]     out_word,
  output logic [MXFADRB:0]                                fifo_count,
  output logic [7:0]                                      ovf_cnt,
  output logic                                            dead_busy
);

  localparam int SLOTW = 1 + MXKEYB + MXQSB + MXBNDB + MXQLTB;
  localparam int DEPTH = 2 ** MXFADRB;

  typedef struct packed {
    logic [MXKEYB-1:0] key;
    logic [MXQSB-1:0]  qs;
    logic [MXBNDB-1:0] bend;
    logic [MXQLTB-1:0] q;
  } cand_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_pipe <= '0;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  // Stage 1: capture both candidates
  logic  s1_vld;
  cand_t s1_c0, s1_c1;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_c0  <= '0;
      s1_c1  <= '0;
    end else begin
      s1_vld <= lut_vld;
      if (lut_vld) begin
        s1_c0 <= '{key: key0, qs: qs0, bend: bend0, q: quality0};
        s1_c1 <= '{key: key1, qs: qs1, bend: bend1, q: quality1};
      end
    end
  end

  // Sort and accept decision on stage-1 data
  logic                   v0, v1, swap;
  logic [SLOTW-1:0]       slot0, slot1;
  logic [2*SLOTW-1:0]     word;
  logic [3:0]             dead_cnt;
  logic                   accept, pop, full, push, drop;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    v0    = (s1_c0.q != '0) && (s1_c0.q >= qlt_thresh);
    v1    = (s1_c1.q != '0) && (s1_c1.q >= qlt_thresh);
    swap  = v1 && (!v0 || (s1_c1.q > s1_c0.q));
    slot0 = {1'b1, (swap ? s1_c1 : s1_c0)};
    slot1 = '0;
    if (v0 && v1) slot1 = {1'b1, (swap ? s1_c0 : s1_c1)};
    word  = {slot1, slot0};
  end

  assign accept = s1_vld && (v0 || v1) && (dead_cnt == 4'd0);
  assign pop    = out_vld && out_rdy;
  assign full   = (fifo_count == (MXFADRB+1)'(DEPTH));
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  // Dead time only restarts on a word that actually reached the FIFO.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                 dead_cnt <= 4'd0;
    else if (push)              dead_cnt <= dead_time;
    else if (dead_cnt != 4'd0)  dead_cnt <= dead_cnt - 4'd1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                       ovf_cnt <= 8'd0;
    else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end

  // FIFO
  logic [2*SLOTW-1:0]  mem [DEPTH];
  logic [MXFADRB-1:0]  wr_ptr, rd_ptr;

  // NOTE: storage array has no reset; the count gates every read of it.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign out_vld   = (fifo_count != '0);
  assign out_word  = out_vld ? mem[rd_ptr] : '0;
  assign dead_busy = (dead_cnt != 4'd0);

endmodule
